// File: rtl/mult_seq.sv
// ============================================================================
// mult_seq : 32x32 signed sequential multiplier with HI/LO registers
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mult_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_begin,
    input  logic [31:0] mult_op1,
    input  logic [31:0] mult_op2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] hi_wdata,
    input  logic        flush,
    output logic        mult_busy,
    output logic        mult_end,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int          WIDTH    = 32;
    localparam logic [5:0]  c_LAST   = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_acc;
    logic [5:0]          r_count;
    logic                r_sign;

    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_result;

    // Unsigned magnitude; 0x80000000 maps onto itself, which reads as 2^31.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs decode the registered state only; no input reaches them.
    always_comb begin
        w_state_next = r_state;
        mult_busy    = 1'b0;
        mult_end     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mult_begin) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                mult_busy = 1'b1;
                if (r_count == c_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                mult_busy    = 1'b1;
                mult_end     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_result = r_sign ? (~r_acc + 64'd1) : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (mthi) begin
                        hi <= hi_wdata;
                    end
                    if (mtlo) begin
                        lo <= hi_wdata;
                    end
                    if (mult_begin) begin
                        r_mcand  <= f_abs(mult_op1);
                        r_mplier <= f_abs(mult_op2);
                        r_sign   <= mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                ST_CALC: begin
                    // Carry out of the upper-half add shifts in at bit 63.
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + 6'd1;
                end
                ST_DONE: begin
                    {hi, lo} <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// tb_mult_seq : directed self-checking bench for mult_seq
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi_wdata;
    logic        flush;
    logic        mult_busy;
    logic        mult_end;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_seq dut (
        .clk        (clk),
        .reset      (reset),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .hi_wdata   (hi_wdata),
        .flush      (flush),
        .mult_busy  (mult_busy),
        .mult_end   (mult_end),
        .hi         (hi),
        .lo         (lo)
    );

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: cycles left until the operation retires, plus HI/LO.
    int          m_left  = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [63:0] m_prod  = '0;
    bit          m_known = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare DUT against it.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_left  = 0;
            m_hi    = '0;
            m_lo    = '0;
            m_known = 1'b1;
        end else if (flush) begin
            m_left = 0;
        end else if (m_left == 0) begin
            if (mthi) m_hi = hi_wdata;
            if (mtlo) m_lo = hi_wdata;
            if (mult_begin) begin
                m_prod = longint'($signed(mult_op1)) * longint'($signed(mult_op2));
                m_left = 33;
            end
        end else begin
            if (m_left == 1) {m_hi, m_lo} = m_prod;
            m_left--;
        end
        #1;
        if (m_known) begin
            check("busy", 64'(mult_busy), 64'(m_left != 0));
            check("end",  64'(mult_end),  64'(m_left == 1));
            check("hi",   64'(hi),        64'(m_hi));
            check("lo",   64'(lo),        64'(m_lo));
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        mult_begin = 1'b1;
        mult_op1   = a;
        mult_op2   = b;
        step();
        mult_begin = 1'b0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
    endtask

    task automatic finish();
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (mult_end === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        check("latency", 64'(lat), 64'd33);
        step();
        mult_begin = 1'b0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        int seen;
        reset      = 1'b1;
        mult_begin = 1'b0;
        mult_op1   = '0;
        mult_op2   = '0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        hi_wdata   = '0;
        flush      = 1'b0;
        step();
        step();
        expect_hilo("reset", 32'h0, 32'h0);
        check("reset_busy", 64'(mult_busy), 64'd0);

        // Accepted in the very cycle reset drops.
        reset = 1'b0;
        start(32'd3, 32'd5);
        check("busy_after_accept", 64'(mult_busy), 64'd1);
        finish();
        expect_hilo("3x5", 32'h0, 32'd15);

        start(32'hFFFF_FFFE, 32'd7);
        finish();
        expect_hilo("m2x7", 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        start(32'h8000_0000, 32'h8000_0000);
        finish();
        expect_hilo("min_sq", 32'h4000_0000, 32'h0);

        start(32'h8000_0000, 32'd1);
        finish();
        expect_hilo("min_x1", 32'hFFFF_FFFF, 32'h8000_0000);

        start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        finish();
        expect_hilo("max_sq", 32'h3FFF_FFFF, 32'h0000_0001);

        start(32'hFFFF_FFFB, 32'd3);
        finish();
        expect_hilo("m5x3", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // MTHI in IDLE leaves LO alone.
        mthi     = 1'b1;
        hi_wdata = 32'h0000_1234;
        step();
        mthi = 1'b0;
        expect_hilo("mthi", 32'h0000_1234, 32'hFFFF_FFF1);

        // MTHI/MTLO and mult_begin during busy are ignored.
        start(32'd2, 32'd2);
        mult_begin = 1'b1;
        mult_op1   = 32'd9;
        mult_op2   = 32'd9;
        mthi       = 1'b1;
        mtlo       = 1'b1;
        hi_wdata   = 32'hDEAD_BEEF;
        finish();
        expect_hilo("2x2_busy_mt", 32'h0, 32'd4);
        step();
        check("no_restart_busy", 64'(mult_busy), 64'd0);

        start(32'd0, 32'h1234_5678);
        finish();
        expect_hilo("zero", 32'h0, 32'h0);

        // Move and start in the same IDLE cycle; product wins later.
        mthi     = 1'b1;
        mtlo     = 1'b1;
        hi_wdata = 32'h0000_0055;
        start(32'd6, 32'd7);
        expect_hilo("mt_with_begin", 32'h0000_0055, 32'h0000_0055);
        finish();
        expect_hilo("6x7", 32'h0, 32'd42);

        // Flush in CALC cycle 10 drops the product.
        mthi     = 1'b1;
        hi_wdata = 32'h0000_00AA;
        step();
        mthi     = 1'b0;
        mtlo     = 1'b1;
        hi_wdata = 32'h0000_00BB;
        step();
        mtlo = 1'b0;
        start(32'd9, 32'd9);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(mult_busy), 64'd0);
        expect_hilo("flush", 32'h0000_00AA, 32'h0000_00BB);
        seen = 0;
        repeat (40) begin
            step();
            if (mult_end === 1'b1) seen++;
        end
        check("flush_no_end", 64'(seen), 64'd0);
        expect_hilo("flush_late", 32'h0000_00AA, 32'h0000_00BB);

        // Flush beats mult_begin and MTHI in IDLE.
        flush      = 1'b1;
        mult_begin = 1'b1;
        mthi       = 1'b1;
        hi_wdata   = 32'h0000_0077;
        step();
        flush      = 1'b0;
        mult_begin = 1'b0;
        mthi       = 1'b0;
        check("flush_idle_busy", 64'(mult_busy), 64'd0);
        check("flush_idle_hi", 64'(hi), 64'h0000_00AA);

        // Reset in CALC cycle 20.
        start(32'd100, 32'hFFFF_FFFD);
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 64'(mult_busy), 64'd0);
        expect_hilo("rst_mid", 32'h0, 32'h0);
        seen = 0;
        repeat (40) begin
            step();
            if (mult_end === 1'b1) seen++;
        end
        check("rst_no_end", 64'(seen), 64'd0);
        start(32'hFFFF_FFF9, 32'hFFFF_FFF7);
        finish();
        expect_hilo("m7xm9", 32'h0, 32'd63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mult_begin  input  1  EXE holds a valid MULT; sampled only in IDLE.
REQ-005 mult_op1  input  32  rs value, two's complement; sampled with mult_begin.
REQ-006 mult_op2  input  32  rt value, two's complement; sampled with mult_begin.
REQ-007 mthi  input  1  write hi_wdata into HI.
REQ-008 mtlo  input  1  write hi_wdata into LO.
REQ-009 hi_wdata  input  32  MTHI/MTLO source (rs value).
REQ-010 flush  input  1  cancel in-flight multiply (exception/ERET in WB).
REQ-011 mult_busy  output  1  high in CALC and DONE.
REQ-012 mult_end  output  1  one-cycle pulse; HI/LO hold the new product from the following cycle.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, DONE, one-hot or binary encoded.
REQ-016 In IDLE with mult_begin=1 and flush=0, the FSM SHALL latch |op1| as multiplicand, |op2| as multiplier, sign=op1[31]^op2[31], clear the 64-bit accumulator and 6-bit counter, and go to CALC.
REQ-017 |x| SHALL be the 32-bit unsigned magnitude; 0x80000000 SHALL yield 2^31 without error.
REQ-018 Each CALC cycle SHALL add the multiplicand to accumulator[63:32] when multiplier bit0=1, then shift {carry,accumulator} right 1 and the multiplier right 1, and increment the counter.
REQ-019 CALC SHALL last exactly 32 cycles; the FSM goes to DONE when counter reaches 31 and that cycle completes.
REQ-020 In DONE, mult_end SHALL be 1 for exactly that cycle; at the closing edge {hi,lo} SHALL load the accumulator, two's-complement negated over 64 bits when sign=1; the FSM returns to IDLE.
REQ-021 Latency: mult_end SHALL be high in the 33rd cycle after the edge that accepts mult_begin; the next mult_begin is accepted in the cycle after mult_end.
REQ-022 mult_begin in CALC or DONE SHALL be ignored.
REQ-023 mthi/mtlo in IDLE SHALL write hi_wdata to HI/LO at the next edge; both asserted writes both.
REQ-024 mthi/mtlo in CALC or DONE SHALL be ignored; the pipeline stalls them behind mult_busy.
REQ-025 mult_begin with mthi/mtlo in the same IDLE cycle SHALL perform the write and start the multiply; the product later overwrites both.
REQ-026 flush in any state SHALL force IDLE at the next edge, suppress mult_end, and leave HI/LO unchanged; flush with mult_begin in IDLE SHALL not start.
REQ-027 flush SHALL have priority over mthi/mtlo and mult_begin in the same cycle.
REQ-028 The block SHALL be zero-latency-free: mult_busy and mult_end are registered-state decodes only, with no combinational path from inputs.

Reset
REQ-029 reset=1 SHALL force IDLE, hi=0, lo=0, counter=0, mult_busy=0, mult_end=0 at the next edge, overriding all other inputs, including mid-CALC.
REQ-030 After reset deasserts, the first mult_begin SHALL be accepted in the same cycle.

Verification
REQ-031 op1=3, op2=5, begin at edge E -> busy from E; mult_end high in cycle E+33; then hi=0, lo=15.
REQ-032 op1=0xFFFFFFFE, op2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2.
REQ-033 op1=op2=0x80000000 -> hi=0x40000000, lo=0; op1=0x80000000, op2=1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-034 IDLE mthi with hi_wdata=0x1234 -> hi=0x1234 next cycle, lo unchanged; then begin 2x2 with mtlo=1 in the busy window -> mtlo ignored, final lo=4.
REQ-035 flush in CALC cycle 10 with hi=0xAA, lo=0xBB held -> busy=0 next cycle, no mult_end pulse, hi=0xAA, lo=0xBB.
REQ-036 reset asserted in CALC cycle 20 -> next cycle hi=lo=0, busy=0, no mult_end; new begin then completes normally.
